// File: rtl/pcpu_pkg.sv
// Shared pcpu definitions: M-extension funct3 codes, MDU sequencer states, overflow constant.
package pcpu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPrep = 3'd1,
        StIter = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shift-add multiply / restoring shift-subtract divide datapath.
// The vacated bit (product MSB or quotient LSB) is left 0 and filled by the caller from cout.
module mdu_step (
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    input  logic        mul_lsb,
    output logic [63:0] acc_nxt,
    output logic        cout
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic [63:0] sh;

    always_comb begin
        sum     = '0;
        diff    = '0;
        sh      = '0;
        acc_nxt = acc;
        cout    = 1'b0;
        if (div_mode) begin
            sh   = {acc[62:0], 1'b0};
            diff = {1'b0, sh[63:32]} - {1'b0, opnd};
            // A set rem MSB before the shift means the shifted rem exceeds any divisor.
            cout    = diff[32] & ~acc[63];
            acc_nxt = cout ? sh : {diff[31:0], sh[31:0]};
        end else begin
            sum     = {1'b0, acc[63:32]} + (mul_lsb ? {1'b0, opnd} : 33'd0);
            cout    = sum[32];
            acc_nxt = {1'b0, sum[31:0], acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: PREP, 32 ITER steps, FIX, DONE.
module mdu_seq
    import pcpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] y
);

    mdu_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] y_q, y_d;

    logic        is_div;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;
    logic        in_div_zero, in_ovf;
    logic [63:0] fix_src, fix_val;
    logic [63:0] step_nxt;
    logic        step_cout;

    assign is_div = op_q[2];

    mdu_step u_step (
        .div_mode (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .mul_lsb  (acc_q[0]),
        .acc_nxt  (step_nxt),
        .cout     (step_cout)
    );

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (op_q)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                sa = a_q[31];
                sb = b_q[31];
            end
            MDU_MULHSU: sa = a_q[31];
            MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU: ;
            default: ;
        endcase
        mag_a = sa ? (~a_q + 32'd1) : a_q;
        mag_b = sb ? (~b_q + 32'd1) : b_q;

        in_div_zero = funct3[2] && (b == 32'd0);
        in_ovf      = ((funct3 == MDU_DIV) || (funct3 == MDU_REM))
                      && (a == DIV_OVF_A) && (b == 32'hFFFF_FFFF);

        // Products use the whole 64-bit acc; quotient sits in lo, remainder in hi.
        if (!is_div)     fix_src = acc_q;
        else if (op_q[1]) fix_src = {32'd0, acc_q[63:32]};
        else             fix_src = {32'd0, acc_q[31:0]};
        fix_val = neg_q ? (~fix_src + 64'd1) : fix_src;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d = funct3;
                    a_d  = a;
                    b_d  = b;
                    if (in_div_zero) begin
                        y_d     = funct3[1] ? a : 32'hFFFF_FFFF;
                        state_d = StDone;
                    end else if (in_ovf) begin
                        y_d     = funct3[1] ? 32'd0 : DIV_OVF_A;
                        state_d = StDone;
                    end else begin
                        state_d = StPrep;
                    end
                end
            end
            StPrep: begin
                cnt_d   = '0;
                neg_d   = (is_div && op_q[1]) ? sa : (sa ^ sb);
                state_d = StIter;
                if (is_div) begin
                    acc_d  = {32'd0, mag_a};
                    opnd_d = mag_b;
                end else begin
                    acc_d  = {32'd0, mag_b};
                    opnd_d = mag_a;
                end
            end
            StIter: begin
                acc_d = is_div ? {step_nxt[63:1], ~step_cout} : {step_cout, step_nxt[62:0]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITERS - 1)) state_d = StFix;
            end
            StFix: begin
                y_d     = (op_q == MDU_MUL || is_div) ? fix_val[31:0] : fix_val[63:32];
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // The result is already committed once in DONE, so flush only aborts earlier states.
        if (flush && (state_q == StPrep || state_q == StIter || state_q == StFix)) begin
            state_d = StIdle;
            y_d     = y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign y    = y_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: results, latency, flush, reset and ignored starts.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .y      (y)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; the start is sampled on the next posedge (cycle 0).
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ey, input int elat);
        int lat;
        bit busy_ok;
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " y"}, {32'd0, y}, {32'd0, ey});
        check({tag, " busy"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        check({tag, " idle"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("reset state", {29'd0, busy, done, (y == 32'd0)}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("DIV",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35);
        run_op("REM",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35);
        run_op("DIVU",   3'd5, 32'd100,      32'd7,        32'd14,        35);
        run_op("REMU",   3'd7, 32'd100,      32'd7,        32'd2,         35);
        run_op("DIVU0",  3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("DIVovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REMovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
        run_op("REMU0",  3'd7, 32'd5,        32'd0,        32'd5,         1);

        // Flush at cycle 10 of a DIVU, then restart at cycle 11.
        funct3 = 3'd5;
        a      = 32'd1000;
        b      = 32'd3;
        start  = 1'b1;
        ndone  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush no done", 64'(ndone) + {63'd0, done}, 64'd0);
        check("flush y held", {32'd0, y}, 64'd5);
        run_op("restart", 3'd5, 32'd1000, 32'd3, 32'd333, 35);

        // Starts during busy and in the DONE cycle must be ignored.
        funct3     = 3'd0;
        a          = 32'd6;
        b          = 32'd7;
        start      = 1'b1;
        ndone      = 0;
        first_done = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 35);
            if (k == 5) begin
                funct3 = 3'd5;
                a      = 32'd9;
                b      = 32'd0;
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
        end
        start = 1'b0;
        check("ignored start dones", 64'(ndone), 64'd1);
        check("ignored start latency", 64'(first_done), 64'd35);
        check("ignored start y", {32'd0, y}, 64'd42);
        check("ignored start idle", {63'd0, busy}, 64'd0);

        // Reset at cycle 20 of a MUL.
        funct3 = 3'd0;
        a      = 32'd3;
        b      = 32'd5;
        start  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midop reset busy", {63'd0, busy}, 64'd0);
        check("midop reset done", {63'd0, done}, 64'd0);
        check("midop reset y", {32'd0, y}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midop reset no done", 64'(ndone), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer beside the pcpu ALU in the execute stage.
- Accepts one M-extension op per start pulse and iterates a 32-step shift-add (multiply) or restoring shift-subtract (divide) datapath.
- Returns a 32-bit result with a one-cycle done pulse.
- The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  op request; sampled only in IDLE
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  32  rs1 operand
- b  in  32  rs2 operand
- flush  in  1  abort current op (trap/redirect)
- busy  out  1  high from the cycle after accepted start until done cycle, inclusive
- done  out  1  one-cycle pulse; result valid
- y  out  32  result; registered, held until next accepted start

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n.
- Reset: state=IDLE; busy=0; done=0; y=0; all internal registers cleared. Reset mid-operation abandons the op with no done.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches funct3, a, b.
  - Divide with b==0, or signed divide with a==0x80000000 and b==0xFFFFFFFF, goes straight to DONE.
  - All other ops go to PREP.
- PREP (1 cycle):
  - Form unsigned magnitudes per signedness: MULH is s*s; MULHSU is s*u; DIV/REM are s/s; MUL, MULHU, DIVU and REMU are u.
  - Record result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clear the 64-bit acc and the counter; go to ITER.
- ITER (exactly ITERS cycles, counter 0..31):
  - Multiply: if multiplier LSB is 1, acc_hi += multiplicand using a 33-bit add; then shift {carry, acc} right 1.
  - Divide: shift {rem, quot} left 1; trial = rem - divisor using a 33-bit subtract; if no borrow, rem = trial and quot LSB = 1.
  - Counter==31 goes to FIX.
- FIX (1 cycle):
  - Two's-complement negate the 64-bit product, quotient or remainder if its recorded sign is 1.
  - Select the output: low word for MUL; high word for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Load y; go to DONE.
- DONE (1 cycle): done=1; busy=1; next state IDLE. A start in this cycle is ignored.
- Special results (y loaded on the IDLE->DONE transition):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=a.
  - Signed overflow: quotient=0x80000000, remainder=0.
- Latency (start in cycle 0):
  - Normal op: done in cycle 35; ITER in cycles 2..33, FIX in cycle 34.
  - Special case: done in cycle 1.
  - Throughput: one op per 36 cycles, since IDLE must be re-entered.
- flush:
  - In any non-IDLE state: next state IDLE, no done, y unchanged.
  - flush together with start in IDLE: start is ignored.
  - flush in the DONE cycle: done still pulses, because the result was already committed.
- Arithmetic:
  - All internal adds and subtracts are 33 bits wide; carry and borrow come from bit 32.
  - The 64-bit negate is ~x+1 modulo 2^64.

Decomposition:
- Shared package pcpu_pkg holds:
  - funct3 constants MDU_MUL..MDU_REMU.
  - State encoding constants for IDLE/PREP/ITER/FIX/DONE (3 bits).
  - The constant DIV_OVF_A = 0x80000000.
- One natural combinational sub-module, mdu_step:
  - Takes mode (mul/div), acc/rem, multiplicand/divisor and the multiplier LSB.
  - Returns the next 64-bit {hi, lo} and the carry/borrow.
  - mdu_seq instantiates it once and owns all registers and the FSM.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), start at cycle 0 -> done at cycle 35, y=0xFFFFFFEB; busy high cycles 1..35.
- MULH 0x80000000*0x80000000 -> y=0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> y=0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> y=0xFFFFFFFD; REM with the same operands -> y=0xFFFFFFFF; DIVU 100/7 -> y=14; REMU 100/7 -> y=2.
- DIVU 5/0 -> y=0xFFFFFFFF, done at cycle 1; REMU 5/0 -> y=5.
- DIV 0x80000000/0xFFFFFFFF -> y=0x80000000, done at cycle 1; REM with the same operands -> y=0.
- flush=1 at cycle 10 of a DIVU -> no done, busy=0 at cycle 11, y keeps the prior value; a new start at cycle 11 completes at cycle 46.
- rst_n=0 at cycle 20 of a MUL -> cycle 21: busy=0, done=0, y=0.
- start pulsed during busy or during the DONE cycle -> ignored, no second done.
